// File: rtl/clk_gate_ctrl.sv
// Sleep/wake controller producing the enable for the core clock-gate cell.
// Optional gated-cycle statistics counter is enabled by defining CLK_GATE_STATS_EN.
module clk_gate_ctrl #(
  parameter int IdleCycles = 16,
  parameter int WakeDelay  = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        test_en_i,
  input  logic        core_sleep_i,
  input  logic        bus_busy_i,
  input  logic        wake_req_i,
  output logic        clk_en_o,
  output logic        gated_o,
  output logic        wake_ack_o,
  input  logic        stats_clr_i,
  output logic [31:0] gate_cycles_o
);

  if (IdleCycles < 1 || IdleCycles > 65535) begin : g_bad_idle
    $error("clk_gate_ctrl: IdleCycles must be in 1..65535");
  end
  if (WakeDelay < 1 || WakeDelay > 255) begin : g_bad_wake
    $error("clk_gate_ctrl: WakeDelay must be in 1..255");
  end

  localparam logic [15:0] IdleLast = 16'(IdleCycles - 1);
  localparam logic [7:0]  WakeLast = 8'(WakeDelay - 1);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    GATED  = 2'd1,
    WAKE   = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [15:0] idle_cnt, idle_next;
  logic [7:0]  wake_cnt, wake_next;
  logic        fsm_en, fsm_en_next;
  logic        gated, gated_next;
  logic        wake_ack, wake_ack_next;
  logic        qual;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ACTIVE;
      idle_cnt <= '0;
      wake_cnt <= '0;
      fsm_en   <= 1'b1;
      gated    <= 1'b0;
      wake_ack <= 1'b0;
    end else begin
      state    <= state_next;
      idle_cnt <= idle_next;
      wake_cnt <= wake_next;
      fsm_en   <= fsm_en_next;
      gated    <= gated_next;
      wake_ack <= wake_ack_next;
    end
  end

  always_comb begin
    qual          = core_sleep_i & ~bus_busy_i & ~wake_req_i;
    state_next    = state;
    idle_next     = idle_cnt;
    wake_next     = wake_cnt;
    wake_ack_next = 1'b0;
    case (state)
      ACTIVE: begin
        if (!qual) begin
          idle_next = '0;
        end else if (idle_cnt == IdleLast) begin
          state_next = GATED;
          idle_next  = '0;
        end else begin
          idle_next = idle_cnt + 16'd1;
        end
      end
      GATED: begin
        idle_next = '0;
        if (wake_req_i) begin
          state_next = WAKE;
          wake_next  = '0;
        end
      end
      WAKE: begin
        idle_next = '0;
        if (wake_cnt == WakeLast) begin
          state_next    = ACTIVE;
          wake_next     = '0;
          wake_ack_next = 1'b1;
        end else begin
          wake_next = wake_cnt + 8'd1;
        end
      end
      default: begin
        state_next = ACTIVE;
        idle_next  = '0;
        wake_next  = '0;
      end
    endcase
    // Output flops are loaded from the next state so they stay glitch-free registers.
    fsm_en_next = (state_next != GATED);
    gated_next  = (state_next == GATED);
  end

  assign clk_en_o   = fsm_en | test_en_i;
  assign gated_o    = gated;
  assign wake_ack_o = wake_ack;

`ifdef CLK_GATE_STATS_EN
  logic [31:0] gate_cycles;

  // Clear has priority over counting; the count sticks at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gate_cycles <= '0;
    end else if (stats_clr_i) begin
      gate_cycles <= '0;
    end else if (state == GATED && gate_cycles != 32'hFFFF_FFFF) begin
      gate_cycles <= gate_cycles + 32'd1;
    end
  end

  assign gate_cycles_o = gate_cycles;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr_i;
  assign gate_cycles_o    = '0;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: a behavioural sleep/wake model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_clk_gate_ctrl;

  localparam int IdleCycles = 16;
  localparam int WakeDelay  = 2;
  localparam longint SatMax = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        test_en = 1'b0;
  logic        core_sleep = 1'b0;
  logic        bus_busy = 1'b0;
  logic        wake_req = 1'b0;
  logic        stats_clr = 1'b0;
  logic        clk_en;
  logic        gated;
  logic        wake_ack;
  logic [31:0] gate_cycles;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clk_gate_ctrl #(
    .IdleCycles(IdleCycles),
    .WakeDelay (WakeDelay)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .test_en_i    (test_en),
    .core_sleep_i (core_sleep),
    .bus_busy_i   (bus_busy),
    .wake_req_i   (wake_req),
    .clk_en_o     (clk_en),
    .gated_o      (gated),
    .wake_ack_o   (wake_ack),
    .stats_clr_i  (stats_clr),
    .gate_cycles_o(gate_cycles)
  );

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model in terms of observable behaviour: length of the current qualifying
  // streak, whether the core is asleep, cycles of wake settling left, pending ack.
  bit     m_asleep;
  int     m_streak;
  int     m_settle_left;
  bit     m_ack;
  longint m_gcount;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_asleep      = 1'b0;
      m_streak      = 0;
      m_settle_left = 0;
      m_ack         = 1'b0;
      m_gcount      = 0;
    end else begin
`ifdef CLK_GATE_STATS_EN
      if (stats_clr) m_gcount = 0;
      else if (m_asleep && m_gcount < SatMax) m_gcount = m_gcount + 1;
`endif
      m_ack = 1'b0;
      if (m_asleep) begin
        if (wake_req) begin
          m_asleep      = 1'b0;
          m_settle_left = WakeDelay;
        end
      end else if (m_settle_left > 0) begin
        m_settle_left = m_settle_left - 1;
        if (m_settle_left == 0) m_ack = 1'b1;
      end else if (core_sleep && !bus_busy && !wake_req) begin
        m_streak = m_streak + 1;
        if (m_streak == IdleCycles) begin
          m_asleep = 1'b1;
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model_clk_en", longint'(clk_en), longint'(!m_asleep || test_en));
      checkOutput("model_gated", longint'(gated), longint'(m_asleep));
      checkOutput("model_wake_ack", longint'(wake_ack), longint'(m_ack));
      checkOutput("model_gate_cycles", longint'(gate_cycles), m_gcount);
    end
  end

  task automatic applyStimulus(input logic sleep, input logic busy, input logic wake,
                               input logic test);
    core_sleep = sleep;
    bus_busy   = busy;
    wake_req   = wake;
    test_en    = test;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic edgesToGate(input int limit, output int n);
    n = 0;
    while (gated !== 1'b1 && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic wakeUp();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (WakeDelay + 1) step();
  endtask

  int n;

  initial begin
    $display("[TB] start IdleCycles=%0d WakeDelay=%0d", IdleCycles, WakeDelay);
    repeat (3) step();
    checkOutput("reset_clk_en", longint'(clk_en), 1);
    checkOutput("reset_gated", longint'(gated), 0);
    checkOutput("reset_wake_ack", longint'(wake_ack), 0);
    checkOutput("reset_gate_cycles", longint'(gate_cycles), 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Continuous idle: gating after exactly IdleCycles edges.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    edgesToGate(200, n);
    checkOutput("t1_edges_to_gate", n, 16);
    checkOutput("t1_clk_en", longint'(clk_en), 0);

    // Wake from GATED.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_clk_en_restored", longint'(clk_en), 1);
    checkOutput("t3_gated_low", longint'(gated), 0);
    checkOutput("t3_ack_wake1", longint'(wake_ack), 0);
    step();
    checkOutput("t3_ack_wake2", longint'(wake_ack), 0);
    step();
    checkOutput("t3_ack_pulse", longint'(wake_ack), 1);
    step();
    checkOutput("t3_ack_gone", longint'(wake_ack), 0);
    repeat (2) step();

    // One busy cycle on the 11th edge restarts the count: 27 edges total.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) step();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    edgesToGate(200, n);
    checkOutput("t2_edges_to_gate", n + 11, 27);
    wakeUp();

    // Wake request on the threshold edge blocks gating and restarts the count.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (15) step();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("t4_not_gated", longint'(gated), 0);
    checkOutput("t4_clk_en", longint'(clk_en), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    edgesToGate(200, n);
    checkOutput("t4_edges_after_restart", n, 16);

    // Test mode overrides the enable only.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("t5_test_clk_en", longint'(clk_en), 1);
    step();
    checkOutput("t5_test_gated", longint'(gated), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("t5_test_off_clk_en", longint'(clk_en), 0);

    // Asynchronous reset while gated.
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_async_clk_en", longint'(clk_en), 1);
    checkOutput("t5_async_gated", longint'(gated), 0);
    #1;
    rst_n = 1'b1;
    repeat (3) step();

`ifdef CLK_GATE_STATS_EN
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    edgesToGate(200, n);
    checkOutput("t6_edges_to_gate", n, 16);
    repeat (100) step();
    checkOutput("t6_gate_cycles_100", longint'(gate_cycles), 100);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    checkOutput("t6_clear_wins", longint'(gate_cycles), 0);
    step();
    checkOutput("t6_recount", longint'(gate_cycles), 1);
    wakeUp();
`else
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    edgesToGate(200, n);
    repeat (20) step();
    checkOutput("t6_stats_tied_zero", longint'(gate_cycles), 0);
    wakeUp();
`endif

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
